// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU share arbiter: ALU control codes and requester index type.
package alu_share_arb_pkg;

    localparam logic [3:0] ALU_AND       = 4'b0000;
    localparam logic [3:0] ALU_OR        = 4'b0001;
    localparam logic [3:0] ALU_ADD       = 4'b0010;
    localparam logic [3:0] ALU_SUB       = 4'b0110;
    localparam logic [3:0] ALU_SLT       = 4'b0111;
    localparam logic [3:0] ALU_NOR       = 4'b1100;
    localparam logic [3:0] ALU_IDLE_CTRL = 4'b0000;

    typedef logic [0:0] req_idx_t;

    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant logic; the pointer remembers the last granted requester
// so that the other one wins the next tie.
module alu_share_arb_rr_arb2
    import alu_share_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic elig0,
    input  logic elig1,
    output logic gnt0,
    output logic gnt1
);

    req_idx_t last_r;
    logic     gnt0_s;
    logic     gnt1_s;

    // Grant selection: a lone eligible requester wins, a tie goes away from last_r
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (elig0 && elig1) begin
            gnt0_s = (last_r == REQ1);
            gnt1_s = (last_r == REQ0);
        end else begin
            gnt0_s = elig0;
            gnt1_s = elig1;
        end
    end

    // Last-grant pointer; resets to requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= REQ1;
        end else if (gnt0_s) begin
            last_r <= REQ0;
        end else if (gnt1_s) begin
            last_r <= REQ1;
        end else begin
            last_r <= last_r;
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto one external single-cycle ALU and buffers each
// requester's result/zero flag in a one-deep valid/ready response slot.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [CTRL_W-1:0] ctrl0,
    input  logic [CTRL_W-1:0] ctrl1,
    input  logic [WIDTH-1:0]  a0,
    input  logic [WIDTH-1:0]  b0,
    input  logic [WIDTH-1:0]  a1,
    input  logic [WIDTH-1:0]  b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    input  logic              rsp_ready0,
    input  logic              rsp_ready1,
    output logic [WIDTH-1:0]  rsp_result0,
    output logic [WIDTH-1:0]  rsp_result1,
    output logic              rsp_zero0,
    output logic              rsp_zero1,
    output logic [CTRL_W-1:0] alu_control,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);

    logic              elig0_s;
    logic              elig1_s;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              rsp_valid0_r;
    logic              rsp_valid1_r;
    logic [WIDTH-1:0]  rsp_result0_r;
    logic [WIDTH-1:0]  rsp_result1_r;
    logic              rsp_zero0_r;
    logic              rsp_zero1_r;
    logic [CTRL_W-1:0] alu_control_s;
    logic [WIDTH-1:0]  alu_a_s;
    logic [WIDTH-1:0]  alu_b_s;

    // A full slot may still accept a new op if it is being drained this cycle
    assign elig0_s = req0 & (~rsp_valid0_r | rsp_ready0);
    assign elig1_s = req1 & (~rsp_valid1_r | rsp_ready1);

    alu_share_arb_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .elig0 (elig0_s),
        .elig1 (elig1_s),
        .gnt0  (gnt0_s),
        .gnt1  (gnt1_s)
    );

    // ALU operand/control mux; parks at the idle code with zero operands when nothing is granted
    always_comb begin
        alu_control_s = CTRL_W'(ALU_IDLE_CTRL);
        alu_a_s       = {WIDTH{1'b0}};
        alu_b_s       = {WIDTH{1'b0}};
        if (gnt0_s) begin
            alu_control_s = ctrl0;
            alu_a_s       = a0;
            alu_b_s       = b0;
        end else if (gnt1_s) begin
            alu_control_s = ctrl1;
            alu_a_s       = a1;
            alu_b_s       = b1;
        end else begin
            alu_control_s = CTRL_W'(ALU_IDLE_CTRL);
            alu_a_s       = {WIDTH{1'b0}};
            alu_b_s       = {WIDTH{1'b0}};
        end
    end

    // Requester 0 response slot: a load wins over a simultaneous pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid0_r  <= 1'b0;
            rsp_result0_r <= {WIDTH{1'b0}};
            rsp_zero0_r   <= 1'b0;
        end else if (gnt0_s) begin
            rsp_valid0_r  <= 1'b1;
            rsp_result0_r <= alu_result;
            rsp_zero0_r   <= alu_zero;
        end else if (rsp_valid0_r && rsp_ready0) begin
            rsp_valid0_r  <= 1'b0;
        end else begin
            rsp_valid0_r  <= rsp_valid0_r;
        end
    end

    // Requester 1 response slot: a load wins over a simultaneous pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid1_r  <= 1'b0;
            rsp_result1_r <= {WIDTH{1'b0}};
            rsp_zero1_r   <= 1'b0;
        end else if (gnt1_s) begin
            rsp_valid1_r  <= 1'b1;
            rsp_result1_r <= alu_result;
            rsp_zero1_r   <= alu_zero;
        end else if (rsp_valid1_r && rsp_ready1) begin
            rsp_valid1_r  <= 1'b0;
        end else begin
            rsp_valid1_r  <= rsp_valid1_r;
        end
    end

    assign gnt0        = gnt0_s;
    assign gnt1        = gnt1_s;
    assign rsp_valid0  = rsp_valid0_r;
    assign rsp_valid1  = rsp_valid1_r;
    assign rsp_result0 = rsp_result0_r;
    assign rsp_result1 = rsp_result1_r;
    assign rsp_zero0   = rsp_zero0_r;
    assign rsp_zero1   = rsp_zero1_r;
    assign alu_control = alu_control_s;
    assign alu_a       = alu_a_s;
    assign alu_b       = alu_b_s;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed cycles push expected responses,
// an independent monitor pops and compares on every response handshake.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [3:0]  ctrl0, ctrl1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1;
    logic        rsp_valid0, rsp_valid1;
    logic        rsp_ready0, rsp_ready1;
    logic [31:0] rsp_result0, rsp_result1;
    logic        rsp_zero0, rsp_zero1;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    // pending operation per requester and its hand-computed {result, zero}
    logic [3:0]  op_c [2];
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic [32:0] pend [2];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    alu_share_arb #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .ctrl0(ctrl0), .ctrl1(ctrl1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .rsp_result0(rsp_result0), .rsp_result1(rsp_result1),
        .rsp_zero0(rsp_zero0), .rsp_zero1(rsp_zero1),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external single-cycle ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z);
        op_c[i] = c;
        op_a[i] = a;
        op_b[i] = b;
        pend[i] = {res, z};
    endtask

    // one cycle: drive after the rising edge, check grant/ALU drive on the falling edge
    task automatic step(input logic r0, input logic r1, input logic rd0, input logic rd1,
                        input logic eg0, input logic eg1);
        @(posedge clk);
        #1;
        req0 = r0; req1 = r1; rsp_ready0 = rd0; rsp_ready1 = rd1;
        ctrl0 = op_c[0]; a0 = op_a[0]; b0 = op_b[0];
        ctrl1 = op_c[1]; a1 = op_a[1]; b1 = op_b[1];
        if (eg0) q0.push_back(pend[0]);
        if (eg1) q1.push_back(pend[1]);
        @(negedge clk);
        check("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        check("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        if (eg0) begin
            check("alu_control0", {28'd0, alu_control}, {28'd0, op_c[0]});
            check("alu_a0", alu_a, op_a[0]);
            check("alu_b0", alu_b, op_b[0]);
        end else if (eg1) begin
            check("alu_control1", {28'd0, alu_control}, {28'd0, op_c[1]});
            check("alu_a1", alu_a, op_a[1]);
            check("alu_b1", alu_b, op_b[1]);
        end else begin
            check("alu_control_idle", {28'd0, alu_control}, 32'd0);
            check("alu_a_idle", alu_a, 32'd0);
            check("alu_b_idle", alu_b, 32'd0);
        end
    endtask

    // monitor: every consumed response must match the oldest expected entry
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid0 && rsp_ready0) begin
                if (q0.size() == 0) begin
                    check("rsp0_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("rsp_result0", rsp_result0, e[32:1]);
                    check("rsp_zero0", {31'd0, rsp_zero0}, {31'd0, e[0]});
                end
            end
            if (!reset && rsp_valid1 && rsp_ready1) begin
                if (q1.size() == 0) begin
                    check("rsp1_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("rsp_result1", rsp_result1, e[32:1]);
                    check("rsp_zero1", {31'd0, rsp_zero1}, {31'd0, e[0]});
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
        ctrl0 = 4'd0; ctrl1 = 4'd0; a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        for (int i = 0; i < 2; i++) set_op(i, ALU_AND, 32'd0, 32'd0, 32'd0, 1'b1);
        #12;
        check("reset_valid0", {31'd0, rsp_valid0}, 32'd0);
        check("reset_valid1", {31'd0, rsp_valid1}, 32'd0);
        check("reset_result0", rsp_result0, 32'd0);
        check("reset_result1", rsp_result1, 32'd0);
        check("reset_zero0", {31'd0, rsp_zero0}, 32'd0);
        check("reset_zero1", {31'd0, rsp_zero1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // contention straight after reset: 0,1,0,1
        set_op(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0);
        set_op(1, ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // single requests
        set_op(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_op(0, ALU_SLT, 32'hFFFF_FFFB, 32'd9, 32'd1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // backpressure on requester 0 while requester 1 keeps issuing
        set_op(0, ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        set_op(0, ALU_ADD, 32'd100, 32'd1, 32'd101, 1'b0);
        set_op(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // zero flag, then an idle cycle
        set_op(1, ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset drops a buffered response
        set_op(1, ALU_ADD, 32'd7, 32'd8, 32'd15, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("valid1_before_reset", {31'd0, rsp_valid1}, 32'd1);
        check("result1_before_reset", rsp_result1, 32'd15);
        #1;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("async_valid1", {31'd0, rsp_valid1}, 32'd0);
        check("async_result1", rsp_result1, 32'd0);
        q1.delete();
        @(negedge clk);
        reset = 1'b0;

        // after reset requester 0 wins the first tie again
        set_op(0, ALU_NOR, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 1'b0);
        set_op(1, ALU_SUB, 32'd9, 32'd2, 32'd7, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
